// File: rtl/tinyalu_op_driver.sv
// Pin-level TinyALU driver: valid/ready operation in, start/op/A/B out, tagged result back.
// Optional watchdog timeout on alu_done is compiled in with `define TINYALU_DRV_TIMEOUT_EN.
module tinyalu_op_driver #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DATA_W-1:0]   res_data,
    output logic [2:0]            res_op,
    output logic                  res_err,
    output logic                  alu_start,
    output logic [2:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic                  alu_done,
    input  logic [2*DATA_W-1:0]   alu_result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_MAX = 3'd4;

    state_e                state_q;
    logic                  res_valid_q;
    logic [2*DATA_W-1:0]   res_data_q;
    logic [2:0]            res_op_q;
    logic                  res_err_q;
    logic                  alu_start_q;
    logic [2:0]            alu_op_q;
    logic [DATA_W-1:0]     alu_a_q;
    logic [DATA_W-1:0]     alu_b_q;

`ifdef TINYALU_DRV_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
            alu_start_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
`ifdef TINYALU_DRV_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        if (op_code <= OP_MAX) begin
                            alu_start_q <= 1'b1;
                            alu_op_q    <= op_code;
                            alu_a_q     <= op_a;
                            alu_b_q     <= op_b;
`ifdef TINYALU_DRV_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                            state_q     <= DRIVE;
                        end else begin
                            res_valid_q <= 1'b1;
                            res_data_q  <= '0;
                            res_op_q    <= op_code;
                            res_err_q   <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end
                end

                DRIVE: begin
`ifdef TINYALU_DRV_TIMEOUT_EN
                    cnt_q <= cnt_q + 8'd1;
`endif
                    // Priority: no_op completes unconditionally, then done, then watchdog.
                    if (alu_op_q == OP_NOP) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= '0;
                        res_op_q    <= alu_op_q;
                        res_err_q   <= 1'b0;
                        alu_start_q <= 1'b0;
                        alu_op_q    <= '0;
                        alu_a_q     <= '0;
                        alu_b_q     <= '0;
                        state_q     <= HOLD;
                    end else if (alu_done) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= alu_result;
                        res_op_q    <= alu_op_q;
                        res_err_q   <= 1'b0;
                        alu_start_q <= 1'b0;
                        alu_op_q    <= '0;
                        alu_a_q     <= '0;
                        alu_b_q     <= '0;
                        state_q     <= HOLD;
                    end
`ifdef TINYALU_DRV_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= '1;
                        res_op_q    <= alu_op_q;
                        res_err_q   <= 1'b1;
                        alu_start_q <= 1'b0;
                        alu_op_q    <= '0;
                        alu_a_q     <= '0;
                        alu_b_q     <= '0;
                        state_q     <= HOLD;
                    end
`endif
                end

                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_data_q  <= '0;
                        res_op_q    <= '0;
                        res_err_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                    alu_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_err   = res_err_q;
    assign alu_start = alu_start_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;

endmodule

// File: tb/tb_tinyalu_op_driver.sv
// Self-checking bench for tinyalu_op_driver: directed cases plus randomized operations
// scored against a transaction-level model; follows TINYALU_DRV_TIMEOUT_EN like the RTL.
module tb_tinyalu_op_driver;

    localparam int unsigned DW = 8;
    localparam int unsigned T  = 16;
`ifdef TINYALU_DRV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [2:0]      op_code = '0;
    logic [DW-1:0]   op_a = '0;
    logic [DW-1:0]   op_b = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [2*DW-1:0] res_data;
    logic [2:0]      res_op;
    logic            res_err;
    logic            alu_start;
    logic [2:0]      alu_op;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic            alu_done = 1'b0;
    logic [2*DW-1:0] alu_result = '0;
    logic            busy;

    int unsigned n_asserts = 0;
    int unsigned n_fails   = 0;

    tinyalu_op_driver #(.DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .res_err(res_err),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference TinyALU arithmetic
    function automatic logic [2*DW-1:0] alu_ref(input logic [2:0] code, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic [2*DW-1:0] ea, eb;
        ea = {{DW{1'b0}}, a};
        eb = {{DW{1'b0}}, b};
        case (code)
            3'd1:    return ea + eb;
            3'd2:    return ea & eb;
            3'd3:    return ea ^ eb;
            3'd4:    return ea * eb;
            default: return '0;
        endcase
    endfunction

    // One transaction: done_delay = drive cycle in which done is raised (0 = never)
    task automatic run_op(input string tag, input logic [2:0] code, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int unsigned done_delay,
                          input int unsigned stall);
        int unsigned exp_starts, starts, cyc;
        bit illegal, timed_out, pins_ok, stable;
        logic [2*DW-1:0] exp_data, held;

        illegal   = (code > 3'd4);
        timed_out = 1'b0;
        if (illegal)
            exp_starts = 0;
        else if (code == 3'd0)
            exp_starts = 1;
        else if (TO_EN && (done_delay == 0 || done_delay > T)) begin
            exp_starts = T;
            timed_out  = 1'b1;
        end else
            exp_starts = done_delay;
        exp_data = (illegal || code == 3'd0) ? '0 : (timed_out ? '1 : alu_ref(code, a, b));

        check({tag, ".ready_before"}, {31'd0, op_ready}, 32'd1);
        op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
        tick();
        op_valid = 1'b0; op_code = $urandom; op_a = $urandom; op_b = $urandom;

        starts = 0; cyc = 0; pins_ok = 1'b1;
        while (res_valid !== 1'b1 && cyc < 300) begin
            if (alu_start === 1'b1) begin
                starts++;
                if (alu_op !== code || alu_a !== a || alu_b !== b) pins_ok = 1'b0;
            end else if (alu_op !== '0 || alu_a !== '0 || alu_b !== '0)
                pins_ok = 1'b0;
            alu_done   = (alu_start === 1'b1 && starts == done_delay);
            alu_result = alu_done ? alu_ref(code, a, b) : 16'($urandom);
            tick();
            alu_done = 1'b0;
            cyc++;
        end
        check({tag, ".res_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, ".latency"}, cyc, exp_starts);
        check({tag, ".start_cycles"}, starts, exp_starts);
        check({tag, ".alu_pins"}, {31'd0, pins_ok}, 32'd1);
        check({tag, ".res_data"}, {16'd0, res_data}, {16'd0, exp_data});
        check({tag, ".res_op"}, {29'd0, res_op}, {29'd0, code});
        check({tag, ".res_err"}, {31'd0, res_err}, {31'd0, illegal || timed_out});
        check({tag, ".start_low"}, {31'd0, alu_start}, 32'd0);

        held = res_data;
        stable = 1'b1;
        for (int unsigned i = 0; i < stall; i++) begin
            alu_done   = (i == 0);
            alu_result = 16'($urandom);
            tick();
            alu_done = 1'b0;
            if (res_valid !== 1'b1 || res_data !== held || op_ready !== 1'b0 ||
                alu_start !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        if (stall > 0) check({tag, ".hold_stable"}, {31'd0, stable}, 32'd1);

        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, ".post_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, ".post_ready"}, {31'd0, op_ready}, 32'd1);
        check({tag, ".post_data"}, {16'd0, res_data}, 32'd0);
    endtask

    initial begin
        bit quiet;

        // Reset state
        reset = 1'b1;
        tick(); tick();
        check("rst.op_ready", {31'd0, op_ready}, 32'd1);
        check("rst.outs", {res_valid, res_err, alu_start, busy, res_op, alu_op},
              32'd0);
        check("rst.data", {res_data, alu_a, alu_b}, 32'd0);
        reset = 1'b0;
        tick();

        run_op("add", 3'd1, 8'hFF, 8'h01, 3, 0);
        run_op("mul", 3'd4, 8'hFF, 8'hFF, 4, 5);
        run_op("nop", 3'd0, 8'h12, 8'h34, 0, 1);
        run_op("ill6", 3'd6, 8'hAA, 8'h55, 2, 2);
`ifdef TINYALU_DRV_TIMEOUT_EN
        run_op("timeout", 3'd3, 8'h0F, 8'hF0, 0, 1);
`else
        run_op("longwait", 3'd3, 8'h0F, 8'hF0, 40, 1);
`endif
        run_op("coincide", 3'd1, 8'h21, 8'h21, T, 0);

        // Reset in the 2nd DRIVE cycle, then a stray done while idle
        op_valid = 1'b1; op_code = 3'd1; op_a = 8'h11; op_b = 8'h22;
        tick();
        op_valid = 1'b0;
        check("mid.drive1", {31'd0, alu_start}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid.start", {31'd0, alu_start}, 32'd0);
        check("mid.valid", {31'd0, res_valid}, 32'd0);
        check("mid.ready", {31'd0, op_ready}, 32'd1);
        check("mid.pins", {16'd0, alu_a, alu_b}, 32'd0);
        alu_done = 1'b1; alu_result = 16'h1234;
        tick();
        alu_done = 1'b0;
        quiet = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (res_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1) quiet = 1'b0;
            tick();
        end
        check("stray_done", {31'd0, quiet}, 32'd1);

        for (int unsigned n = 0; n < 20; n++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                   $urandom_range(1, 20), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
